// File: rtl/da_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : da_sched_pkg
// Purpose  : Shared types and constants for the DA sync scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package da_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SYNC   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RUN    = 3'd4
  } sched_state_e;

  typedef enum logic [1:0] {
    PH_0   = 2'd0,
    PH_90  = 2'd1,
    PH_180 = 2'd2,
    PH_270 = 2'd3
  } phase_e;

  localparam int DIV_RST = 3;

  // Settle counter runs 0..cyc-1, so it needs enough bits for cyc-1.
  function automatic int settle_cnt_w(input int cyc);
    return (cyc <= 2) ? 1 : $clog2(cyc);
  endfunction

endpackage
`default_nettype wire

// File: rtl/da_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : da_rr_arb
// Purpose  : N-way round-robin arbiter, one-hot grant, priority rotates past
//            the last granted requester; clr_i restores requester 0 as highest.
// Revision : 1.0 - initial release
// ============================================================================
module da_rr_arb #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr_i,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  logic [IW-1:0] last_q;
  logic          w_found;

  // First pass looks strictly above the last grant, second pass wraps to 0.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    w_found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && req_i[i] && (i > int'(last_q))) begin
        w_found   = 1'b1;
        gnt_o[i]  = 1'b1;
        gnt_idx_o = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_found && req_i[i]) begin
        w_found   = 1'b1;
        gnt_o[i]  = 1'b1;
        gnt_idx_o = IW'(i);
      end
    end
    gnt_vld_o = w_found;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= IW'(N - 1);
    end else if (clr_i) begin
      last_q <= IW'(N - 1);
    end else if (gnt_vld_o) begin
      last_q <= gnt_idx_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/da_sync_sched.sv
`default_nettype none
// ============================================================================
// Module   : da_sync_sched
// Purpose  : DA channel scheduler - atomic divisor/phase commit, common sync
//            pulse, round-robin sharing of the sample-RAM read port.
//            Optional DA_SCHED_OVR_CNT_EN adds per-channel overrun counters.
// Revision : 1.0 - initial release
// ============================================================================
module da_sync_sched
  import da_sched_pkg::*;
#(
  parameter  int NCH        = 4,
  parameter  int DIV_W      = 8,
  parameter  int PTR_W      = 10,
  parameter  int DATA_W     = 14,
  parameter  int SETTLE_CYC = 16,
  localparam int CH_W       = $clog2(NCH),
  localparam int A_W        = CH_W + PTR_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cfg_wr,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [DIV_W-1:0]     cfg_div,
  input  logic [1:0]           cfg_phase,
  input  logic [PTR_W-1:0]     cfg_len,
  input  logic                 cmd_commit,
  input  logic                 cmd_stop,
  output logic [NCH*DIV_W-1:0] da_divcnt,
  output logic [NCH*2-1:0]     da_phase,
  output logic                 clk_syn,
  input  logic [NCH-1:0]       data_req,
  output logic                 ram_rd_en,
  output logic [A_W-1:0]       ram_addr,
  input  logic [DATA_W-1:0]    ram_rdata,
  output logic [DATA_W-1:0]    ch_data,
  output logic [NCH-1:0]       ch_dvalid,
  output logic                 busy
`ifdef DA_SCHED_OVR_CNT_EN
  ,
  output logic [NCH*16-1:0]    ovr_cnt
`endif
);

  localparam int CNT_W = settle_cnt_w(SETTLE_CYC);

  sched_state_e     state_q;
  logic             clk_syn_q;
  logic             busy_q;
  logic [CNT_W-1:0] settle_cnt_q;

  logic [DIV_W-1:0] shd_div_q [NCH];
  logic [1:0]       shd_ph_q  [NCH];
  logic [DIV_W-1:0] act_div_q [NCH];
  logic [1:0]       act_ph_q  [NCH];

  logic [NCH-1:0]   pend_q, pend_d;
  logic [PTR_W-1:0] ptr_q [NCH];
  logic [NCH-1:0]   rd_q;
  logic [NCH-1:0]   dvalid_q;
  logic [DATA_W-1:0] data_q;

  logic             w_load;
  logic             w_run;
  logic             w_cfg_ch_ok;
  logic [NCH-1:0]   w_arb_req;
  logic [NCH-1:0]   w_gnt;
  logic [CH_W-1:0]  w_gnt_idx;
  logic             w_gnt_vld;
  logic [PTR_W-1:0] w_ptr_cur;
  logic [PTR_W-1:0] w_ptr_nxt;

  assign w_load      = (state_q == ST_LOAD);
  assign w_run       = (state_q == ST_RUN);
  assign w_cfg_ch_ok = (int'(cfg_ch) < NCH);

  // stop beats commit; commit while already in LOAD is absorbed by that LOAD
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      clk_syn_q    <= 1'b0;
      busy_q       <= 1'b0;
      settle_cnt_q <= '0;
    end else begin
      clk_syn_q <= 1'b0;
      if (cmd_stop) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else if (cmd_commit && (state_q != ST_LOAD)) begin
        state_q <= ST_LOAD;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          ST_LOAD: begin
            state_q   <= ST_SYNC;
            clk_syn_q <= 1'b1;
          end
          ST_SYNC: begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= '0;
          end
          ST_SETTLE: begin
            if (settle_cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
              state_q <= ST_RUN;
            end else begin
              settle_cnt_q <= settle_cnt_q + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) begin
        shd_div_q[i] <= DIV_W'(DIV_RST);
        shd_ph_q[i]  <= PH_0;
        act_div_q[i] <= DIV_W'(DIV_RST);
        act_ph_q[i]  <= PH_0;
      end
    end else begin
      if (cfg_wr && w_cfg_ch_ok) begin
        shd_div_q[cfg_ch] <= cfg_div;
        shd_ph_q[cfg_ch]  <= cfg_phase;
      end
      if (w_load) begin
        for (int i = 0; i < NCH; i++) begin
          act_div_q[i] <= shd_div_q[i];
          act_ph_q[i]  <= shd_ph_q[i];
        end
      end
    end
  end

  assign w_arb_req = w_run ? pend_q : '0;

  da_rr_arb #(
    .N (NCH)
  ) u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .clr_i     (w_load),
    .req_i     (w_arb_req),
    .gnt_o     (w_gnt),
    .gnt_idx_o (w_gnt_idx),
    .gnt_vld_o (w_gnt_vld)
  );

  // A request arriving on its own grant cycle survives as the next pending one.
  always_comb begin
    pend_d = pend_q;
    if (w_load || cmd_stop) begin
      pend_d = '0;
    end else if (w_run) begin
      pend_d = (pend_q & ~w_gnt) | data_req;
    end
  end

  assign w_ptr_cur = ptr_q[w_gnt_idx];
  assign w_ptr_nxt = (w_ptr_cur == cfg_len) ? '0 : w_ptr_cur + PTR_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        ptr_q[i] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      if (w_load) begin
        for (int i = 0; i < NCH; i++) begin
          ptr_q[i] <= '0;
        end
      end else if (w_gnt_vld) begin
        ptr_q[w_gnt_idx] <= w_ptr_nxt;
      end
    end
  end

  // Return pipeline is never flushed so an in-flight read always lands.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_q     <= '0;
      dvalid_q <= '0;
      data_q   <= '0;
    end else begin
      rd_q     <= w_gnt;
      dvalid_q <= rd_q;
      if (|rd_q) begin
        data_q <= ram_rdata;
      end
    end
  end

`ifdef DA_SCHED_OVR_CNT_EN
  logic [15:0]    ovr_q [NCH];
  logic [NCH-1:0] w_ovr;

  assign w_ovr = w_run ? (data_req & pend_q & ~w_gnt) : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) begin
        ovr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_load) begin
          ovr_q[i] <= '0;
        end else if (w_ovr[i] && (ovr_q[i] != 16'hFFFF)) begin
          ovr_q[i] <= ovr_q[i] + 16'd1;
        end
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ovr
    assign ovr_cnt[i*16 +: 16] = ovr_q[i];
  end
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_pack
    assign da_divcnt[i*DIV_W +: DIV_W] = act_div_q[i];
    assign da_phase[i*2 +: 2]          = act_ph_q[i];
  end

  assign clk_syn   = clk_syn_q;
  assign busy      = busy_q;
  assign ram_rd_en = w_gnt_vld;
  assign ram_addr  = w_gnt_vld ? {w_gnt_idx, w_ptr_cur} : '0;
  assign ch_data   = data_q;
  assign ch_dvalid = dvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_da_sync_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_da_sync_sched
// Purpose  : Self-checking bench for da_sync_sched with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_da_sync_sched;

  localparam int M_IDLE = 0, M_LOAD = 1, M_SYNC = 2, M_SETTLE = 3, M_RUN = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_wr;
  logic [1:0]  cfg_ch;
  logic [7:0]  cfg_div;
  logic [1:0]  cfg_phase;
  logic [9:0]  cfg_len;
  logic        cmd_commit, cmd_stop;
  logic [31:0] da_divcnt;
  logic [7:0]  da_phase;
  logic        clk_syn;
  logic [3:0]  data_req;
  logic        ram_rd_en;
  logic [11:0] ram_addr;
  logic [13:0] ram_rdata;
  logic [13:0] ch_data;
  logic [3:0]  ch_dvalid;
  logic        busy;
`ifdef DA_SCHED_OVR_CNT_EN
  logic [63:0] ovr_cnt;
`endif

  always #5 clk = ~clk;

  da_sync_sched dut (
    .clk        (clk),
    .rstn       (rstn),
    .cfg_wr     (cfg_wr),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_phase  (cfg_phase),
    .cfg_len    (cfg_len),
    .cmd_commit (cmd_commit),
    .cmd_stop   (cmd_stop),
    .da_divcnt  (da_divcnt),
    .da_phase   (da_phase),
    .clk_syn    (clk_syn),
    .data_req   (data_req),
    .ram_rd_en  (ram_rd_en),
    .ram_addr   (ram_addr),
    .ram_rdata  (ram_rdata),
    .ch_data    (ch_data),
    .ch_dvalid  (ch_dvalid),
    .busy       (busy)
`ifdef DA_SCHED_OVR_CNT_EN
    ,
    .ovr_cnt    (ovr_cnt)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  // behavioural model state (spec-level view of the scheduler)
  int m_mode, m_settle, m_last;
  int m_sdiv[4], m_sph[4], m_adiv[4], m_aph[4];
  bit m_pend[4];
  int m_ptr[4];
  int m_ovr[4];
  int m_rd_ch, m_rd_addr, m_dv_ch, m_data;
  int ram_nx;

  function automatic int mem(input int a);
    return (a * 97 + 13) % 16384;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_settle = 0; m_last = 3;
    for (int i = 0; i < 4; i++) begin
      m_sdiv[i] = 3; m_sph[i] = 0; m_adiv[i] = 3; m_aph[i] = 0;
      m_pend[i] = 0; m_ptr[i] = 0; m_ovr[i] = 0;
    end
    m_rd_ch = -1; m_rd_addr = 0; m_dv_ch = -1; m_data = 0;
  endtask

  function automatic int m_grant();
    if (m_mode != M_RUN) return -1;
    for (int k = 0; k < 4; k++) begin
      if (m_pend[(m_last + 1 + k) % 4]) return (m_last + 1 + k) % 4;
    end
    return -1;
  endfunction

  task automatic compare();
    int g;
    logic [31:0] ediv;
    logic [7:0]  eph;
    g = m_grant();
    for (int i = 0; i < 4; i++) begin
      ediv[i*8 +: 8] = 8'(m_adiv[i]);
      eph[i*2 +: 2]  = 2'(m_aph[i]);
    end
    chk("busy", busy, m_mode != M_IDLE);
    chk("clk_syn", clk_syn, m_mode == M_SYNC);
    chk("da_divcnt", da_divcnt, ediv);
    chk("da_phase", da_phase, eph);
    chk("ram_rd_en", ram_rd_en, g >= 0);
    if (g >= 0) chk("ram_addr", ram_addr, g * 1024 + m_ptr[g]);
    chk("ch_dvalid", ch_dvalid, (m_dv_ch >= 0) ? (1 << m_dv_ch) : 0);
    if (m_dv_ch >= 0) chk("ch_data", ch_data, m_data);
`ifdef DA_SCHED_OVR_CNT_EN
    begin
      logic [63:0] eovr;
      for (int i = 0; i < 4; i++) eovr[i*16 +: 16] = 16'(m_ovr[i]);
      chk("ovr_cnt", ovr_cnt, eovr);
    end
`endif
  endtask

  task automatic model_step(input bit wr, input int ch, input int dv, input int ph,
                            input bit cm, input bit sp, input logic [3:0] rq);
    int g;
    g = m_grant();
    m_dv_ch = m_rd_ch;
    if (m_rd_ch >= 0) m_data = mem(m_rd_addr);
    m_rd_ch = g;
    if (g >= 0) m_rd_addr = g * 1024 + m_ptr[g];
    if (m_mode == M_RUN) begin
      for (int i = 0; i < 4; i++)
        if (rq[i] && m_pend[i] && i != g && m_ovr[i] < 65535) m_ovr[i]++;
    end
    if (m_mode == M_LOAD) begin
      for (int i = 0; i < 4; i++) begin
        m_adiv[i] = m_sdiv[i]; m_aph[i] = m_sph[i];
        m_ptr[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
      end
      m_last = 3;
    end else begin
      if (g >= 0) begin
        m_ptr[g] = (m_ptr[g] == int'(cfg_len)) ? 0 : (m_ptr[g] + 1) % 1024;
        m_last = g;
      end
      for (int i = 0; i < 4; i++) begin
        if (sp) m_pend[i] = 0;
        else if (m_mode == M_RUN) m_pend[i] = (m_pend[i] && i != g) || rq[i];
      end
    end
    if (wr) begin
      m_sdiv[ch] = dv; m_sph[ch] = ph;
    end
    if (sp) m_mode = M_IDLE;
    else if (cm && m_mode != M_LOAD) m_mode = M_LOAD;
    else if (m_mode == M_LOAD) m_mode = M_SYNC;
    else if (m_mode == M_SYNC) begin
      m_mode = M_SETTLE; m_settle = 16;
    end else if (m_mode == M_SETTLE) begin
      m_settle--;
      if (m_settle == 0) m_mode = M_RUN;
    end
  endtask

  // entered and left at a falling edge
  task automatic step(input bit wr, input int ch, input int dv, input int ph,
                      input bit cm, input bit sp, input logic [3:0] rq);
    compare();
    cfg_wr = wr; cfg_ch = 2'(ch); cfg_div = 8'(dv); cfg_phase = 2'(ph);
    cmd_commit = cm; cmd_stop = sp; data_req = rq;
    ram_nx = ram_rd_en ? mem(int'(ram_addr)) : int'($urandom_range(0, 16383));
    model_step(wr, ch, dv, ph, cm, sp, rq);
    @(posedge clk);
    @(negedge clk);
    ram_rdata = 14'(ram_nx);
  endtask

  task automatic nop(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 4'b0000);
  endtask

  initial begin
    rstn = 1'b0; cfg_wr = 0; cfg_ch = 0; cfg_div = 0; cfg_phase = 0; cfg_len = 10'd3;
    cmd_commit = 0; cmd_stop = 0; data_req = 0; ram_rdata = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    nop(2);
    chk("rst_divcnt", da_divcnt, 64'h03030303);
    chk("rst_phase", da_phase, 64'h0);
    chk("rst_busy", busy, 64'h0);
    chk("rst_chdata", ch_data, 64'h0);

    step(1, 1, 9, 2, 1, 0, 4'b0000);
    chk("load_divcnt_held", da_divcnt, 64'h03030303);
    nop(1);
    chk("sync_pulse", clk_syn, 64'h1);
    chk("sync_divcnt", da_divcnt, 64'h03030903);
    chk("sync_phase", da_phase, 64'h08);
    nop(1);
    chk("sync_single", clk_syn, 64'h0);
    step(0, 0, 0, 0, 0, 0, 4'b1111);
    chk("settle_no_rd", ram_rd_en, 64'h0);
    nop(15);
    chk("run_no_pending", ram_rd_en, 64'h0);

    step(0, 0, 0, 0, 0, 0, 4'b1111);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) chk("rr_addr", ram_addr, 64'(i * 1024));
      else chk("rr_idle", ram_rd_en, 64'h0);
      if (i >= 2) chk("rr_dvalid", ch_dvalid, 64'(1 << (i - 2)));
      nop(1);
    end

    step(0, 0, 0, 0, 1, 0, 4'b0000);
    nop(1);
    chk("resync_pulse", clk_syn, 64'h1);
    nop(17);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 0, 0, 0, 4'b0100);
      chk("wrap_addr", ram_addr, 64'(2048 + (k % 4)));
      nop(1);
    end

    step(0, 0, 0, 0, 0, 0, 4'b1111);
    step(0, 0, 0, 0, 1, 0, 4'b1111);
    chk("load_no_rd", ram_rd_en, 64'h0);
    nop(1);
    chk("restart_pulse", clk_syn, 64'h1);
    step(0, 0, 0, 0, 1, 1, 4'b0000);
    chk("stop_wins", busy, 64'h0);
    nop(2);

    for (int n = 0; n < 3000; n++) begin
      logic [3:0] rq;
      if (n % 250 == 0) cfg_len = 10'($urandom_range(0, 5));
      for (int i = 0; i < 4; i++) rq[i] = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 7) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 3)), (n == 0) || ($urandom_range(0, 119) == 0),
           $urandom_range(0, 299) == 0, rq);
    end

    step(0, 0, 0, 0, 1, 0, 4'b0000);
    nop(19);
    step(0, 0, 0, 0, 0, 0, 4'b1111);
    rstn = 1'b0;
    #1;
    chk("arst_busy", busy, 64'h0);
    chk("arst_syn", clk_syn, 64'h0);
    chk("arst_rd_en", ram_rd_en, 64'h0);
    chk("arst_addr", ram_addr, 64'h0);
    chk("arst_dvalid", ch_dvalid, 64'h0);
    chk("arst_chdata", ch_data, 64'h0);
    chk("arst_divcnt", da_divcnt, 64'h03030303);
    model_reset();
    data_req = 0; cmd_commit = 0; cmd_stop = 0; cfg_wr = 0;
    @(negedge clk);
    rstn = 1'b1;
    nop(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
